pipe_stage_reg: RTL and testbench

- Parametrised, generic inter-stage pipeline register for the five-stage core. It replaces the hand-written fixed fetch/decode/execute/memory/writeback register blocks.
- Adds what those blocks lack: a valid/ready handshake for stalls, a flush that injects a bubble, an optional skid entry so the upstream ready can be a registered signal, and a saturating stall-cycle counter.
- One instance sits between each pair of stages. DATA_W carries the packed stage bundle (instruction, PC, control fields).

---
 rtl/pipe_stage_reg.sv | 177 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register for the five-stage core. One instance
// sits between each pair of stages and carries the packed stage bundle
// (instruction, PC, control fields) as an opaque DATA_W-bit payload.
//
// Features:
//   * valid/ready handshake on both sides so a stage can stall its upstream.
//   * i_flush empties the stage and leaves a bubble (NOP_VALUE) on o_data.
//   * SKID_EN=1 adds a second (skid) entry so o_ready comes straight from a
//     register and the ready chain between stages is broken every stage.
//     SKID_EN=0 keeps a single entry and passes ready through combinationally.
//   * Saturating count of cycles in which a valid payload was held back by
//     the downstream stage.
//
// Parameters:
//   DATA_W     payload width
//   NOP_VALUE  payload driven whenever an entry is empty (addi x0,x0,0)
//   SKID_EN    1: two entries, registered o_ready; 0: one entry
//   CNT_W      width of the stall counter
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-high reset
//   i_valid      upstream has a payload
//   o_ready      this stage can accept a payload
//   i_data       upstream payload (held stable while i_valid & !o_ready)
//   o_valid      downstream payload is valid
//   i_ready      downstream accepts the payload
//   o_data       downstream payload (NOP_VALUE when empty)
//   i_flush      discard all held entries
//   o_count      occupancy, 0..2
//   o_stall_cnt  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned        DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_VALUE = 32'h0000_0013,
    parameter bit                 SKID_EN   = 1'b1,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,

    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,

    input  logic              i_flush,
    output logic [1:0]        o_count,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // Encoding is chosen so the state value is the occupancy itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_main;      // entry M, always the head of the queue
    logic [DATA_W-1:0]   r_skid;      // entry S, only ever used when SKID_EN=1
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_valid;
    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_stall;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign w_valid = (r_state != ST_EMPTY);

    generate
        if (SKID_EN) begin : g_skid_ready
            // Registered ready: only the state flops feed it, so the upstream
            // stage never sees a path from the downstream i_ready.
            assign w_ready = (r_state != ST_TWO);
        end else begin : g_pass_ready
            // NOTE: with one entry the stage can only take a new payload in
            // the same cycle as the old one leaves, so ready must look at
            // i_ready combinationally to keep one transfer per cycle.
            assign w_ready = !w_valid || i_ready;
        end
    endgenerate

    assign w_push  = i_valid && w_ready;
    assign w_pop   = w_valid && i_ready;

    // A flushed cycle is a redirect, not a back-pressure stall.
    assign w_stall = w_valid && !i_ready && !i_flush;

    // -------------------------------------------------------------------------
    // State, storage and stall counter
    // -------------------------------------------------------------------------
    // NOTE: all state below is updated with non-blocking assignments so every
    // branch reads the pre-edge values of r_state/r_main/r_skid; a blocking
    // update of r_main before r_skid is read would break the TWO->ONE shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: both payload entries are reset, not just the state, because
            // an empty entry must read back as NOP_VALUE on o_data.
            r_state     <= ST_EMPTY;
            r_main      <= NOP_VALUE;
            r_skid      <= NOP_VALUE;
            r_stall_cnt <= '0;
        end else begin
            // Saturating counter; flush does not clear it.
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            if (i_flush) begin
                // A same-cycle push is dropped; a same-cycle pop has already
                // been presented on o_data/o_valid and completes normally.
                r_state <= ST_EMPTY;
                r_main  <= NOP_VALUE;
                r_skid  <= NOP_VALUE;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_push) begin
                            r_state <= ST_ONE;
                            r_main  <= i_data;
                        end
                    end

                    ST_ONE: begin
                        if (w_push && w_pop) begin
                            // Old head leaves, new payload takes its place.
                            r_main <= i_data;
                        end else if (w_push && SKID_EN) begin
                            // Head stays put; new payload queues behind it.
                            r_state <= ST_TWO;
                            r_skid  <= i_data;
                        end else if (w_pop) begin
                            r_state <= ST_EMPTY;
                            r_main  <= NOP_VALUE;
                        end
                    end

                    ST_TWO: begin
                        // o_ready is low here, so only a pop can happen.
                        if (w_pop) begin
                            r_state <= ST_ONE;
                            r_main  <= r_skid;
                            r_skid  <= NOP_VALUE;
                        end
                    end

                    default: begin
                        r_state <= ST_EMPTY;
                        r_main  <= NOP_VALUE;
                        r_skid  <= NOP_VALUE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_valid     = w_valid;
    assign o_ready     = w_ready;
    assign o_data      = r_main;
    assign o_count     = r_state;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances share one clock: dut_s (SKID_EN=1) and dut_n (SKID_EN=0).
// Directed scenarios run on dut_s, then a randomized run on dut_s, then the
// long stall-counter saturation on dut_s in parallel with a randomized run on
// dut_n. The reference model is a plain queue with a capacity limit.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          DW  = 32;
    localparam int          CW  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_s (skid) signals
    logic          s_reset, s_valid, s_rdy, s_flush;
    logic [DW-1:0] s_data;
    logic          s_o_ready, s_o_valid;
    logic [DW-1:0] s_o_data;
    logic [1:0]    s_o_count;
    logic [CW-1:0] s_o_stall;

    // dut_n (no skid) signals
    logic          n_reset, n_valid, n_rdy, n_flush;
    logic [DW-1:0] n_data;
    logic          n_o_ready, n_o_valid;
    logic [DW-1:0] n_o_data;
    logic [1:0]    n_o_count;
    logic [CW-1:0] n_o_stall;

    pipe_stage_reg #(
        .DATA_W(DW), .NOP_VALUE(NOP), .SKID_EN(1'b1), .CNT_W(CW)
    ) dut_s (
        .clk(clk), .reset(s_reset),
        .i_valid(s_valid), .o_ready(s_o_ready), .i_data(s_data),
        .o_valid(s_o_valid), .i_ready(s_rdy), .o_data(s_o_data),
        .i_flush(s_flush), .o_count(s_o_count), .o_stall_cnt(s_o_stall)
    );

    pipe_stage_reg #(
        .DATA_W(DW), .NOP_VALUE(NOP), .SKID_EN(1'b0), .CNT_W(CW)
    ) dut_n (
        .clk(clk), .reset(n_reset),
        .i_valid(n_valid), .o_ready(n_o_ready), .i_data(n_data),
        .o_valid(n_o_valid), .i_ready(n_rdy), .o_data(n_o_data),
        .i_flush(n_flush), .o_count(n_o_count), .o_stall_cnt(n_o_stall)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the caller 1 time unit after a rising edge, a safe point to drive.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_set(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
        s_valid = v;
        s_data  = d;
        s_rdy   = rdy;
        s_flush = fl;
    endtask

    task automatic n_set(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
        n_valid = v;
        n_data  = d;
        n_rdy   = rdy;
        n_flush = fl;
    endtask

    task automatic s_expect(input string tag, input logic v, input logic [31:0] d,
                            input logic rdy, input logic [1:0] cnt);
        check({tag, "_valid"}, s_o_valid, v);
        check({tag, "_data"},  s_o_data,  d);
        check({tag, "_ready"}, s_o_ready, rdy);
        check({tag, "_count"}, s_o_count, cnt);
    endtask

    // Randomized run against a queue model. skid selects which instance.
    task automatic run_random(input bit skid, input int cycles);
        logic [31:0] q[$];
        int          stall = 0;
        bit          held  = 0;
        logic        v = 1'b0, rdy, fl;
        logic [31:0] d = '0;
        logic        exp_valid, exp_ready;
        logic [31:0] exp_data;
        logic        ov, ordy;
        logic [31:0] od;
        logic [1:0]  oc;
        logic [15:0] os;
        string       pfx;
        pfx = skid ? "rnd_s" : "rnd_n";
        for (int c = 0; c < cycles; c++) begin
            // Upstream must keep a refused payload stable.
            if (!held) begin
                v = ($urandom_range(0, 9) < 6);
                d = $urandom;
            end
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 99) < 4);
            if (skid) s_set(v, d, rdy, fl);
            else      n_set(v, d, rdy, fl);
            #1;
            exp_valid = (q.size() != 0);
            exp_data  = exp_valid ? q[0] : NOP;
            exp_ready = skid ? (q.size() < 2) : (!exp_valid || rdy);
            ov   = skid ? s_o_valid : n_o_valid;
            od   = skid ? s_o_data  : n_o_data;
            ordy = skid ? s_o_ready : n_o_ready;
            oc   = skid ? s_o_count : n_o_count;
            os   = skid ? s_o_stall : n_o_stall;
            check({pfx, "_valid"}, ov,   exp_valid);
            check({pfx, "_data"},  od,   exp_data);
            check({pfx, "_ready"}, ordy, exp_ready);
            check({pfx, "_count"}, oc,   q.size());
            check({pfx, "_stall"}, os,   stall);
            // Model update for the coming edge.
            if (exp_valid && !rdy && !fl && stall < 65535) stall++;
            if (fl) begin
                q.delete();
            end else begin
                if (exp_valid && rdy) void'(q.pop_front());
                if (v && exp_ready)   q.push_back(d);
            end
            held = v && !exp_ready && !fl;
            tick();
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_reset = 1'b1;
        n_reset = 1'b1;
        s_set(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        n_set(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state, with a push being offered during reset.
        s_expect("rst_s", 1'b0, NOP, 1'b1, 2'd0);
        check("rst_s_stall", s_o_stall, 0);
        check("rst_n_valid", n_o_valid, 1'b0);
        check("rst_n_data",  n_o_data,  NOP);
        check("rst_n_ready", n_o_ready, 1'b1);
        check("rst_n_count", n_o_count, 2'd0);

        // First push after release appears one cycle later.
        s_reset = 1'b0;
        n_reset = 1'b0;
        n_set(1'b0, '0, 1'b1, 1'b0);
        tick();
        s_expect("post_rst", 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd1);
        s_set(1'b0, '0, 1'b1, 1'b0);
        tick();
        s_expect("drain0", 1'b0, NOP, 1'b1, 2'd0);

        // Back-to-back stream with the downstream always ready.
        for (int k = 1; k <= 8; k++) begin
            s_set(1'b1, 32'(k), 1'b1, 1'b0);
            tick();
            s_expect($sformatf("stream%0d", k), 1'b1, 32'(k), 1'b1, 2'd1);
        end
        s_set(1'b0, '0, 1'b1, 1'b0);
        tick();
        s_expect("stream_end", 1'b0, NOP, 1'b1, 2'd0);
        check("stream_stall", s_o_stall, 0);

        // Fill both entries while stalled, then drain in order.
        s_set(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        tick();
        s_set(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        tick();
        s_expect("full", 1'b1, 32'hAAAA_0001, 1'b0, 2'd2);
        check("full_stall", s_o_stall, 1);
        s_set(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("full_ready_no_comb", s_o_ready, 1'b0);
        check("drain_a", s_o_data, 32'hAAAA_0001);
        tick();
        s_expect("drain_b", 1'b1, 32'hBBBB_0002, 1'b1, 2'd1);
        tick();
        s_expect("drained", 1'b0, NOP, 1'b1, 2'd0);
        check("drained_stall", s_o_stall, 1);

        // Flush at occupancy 2 with a payload offered.
        s_set(1'b1, 32'hC0C0_0001, 1'b0, 1'b0);
        tick();
        s_set(1'b1, 32'hC0C0_0002, 1'b0, 1'b0);
        tick();
        check("pre_flush_count", s_o_count, 2'd2);
        s_set(1'b1, 32'hCCCC_CCCC, 1'b0, 1'b1);
        tick();
        s_expect("flush2", 1'b0, NOP, 1'b1, 2'd0);
        check("flush2_stall", s_o_stall, 2);
        s_set(1'b0, '0, 1'b1, 1'b0);
        tick();
        s_expect("flush2_after", 1'b0, NOP, 1'b1, 2'd0);

        // Flush at occupancy 1 with a same-cycle push and pop: push dropped.
        s_set(1'b1, 32'hF00D_0001, 1'b1, 1'b0);
        tick();
        s_set(1'b1, 32'hF00D_0002, 1'b1, 1'b1);
        #1;
        check("flush1_pop_data", s_o_data, 32'hF00D_0001);
        tick();
        s_expect("flush1", 1'b0, NOP, 1'b1, 2'd0);
        check("flush1_stall", s_o_stall, 2);

        // Reset in the middle of operation.
        s_set(1'b1, 32'h1111_0001, 1'b0, 1'b0);
        tick();
        s_set(1'b1, 32'h1111_0002, 1'b0, 1'b0);
        tick();
        s_reset = 1'b1;
        s_set(1'b0, '0, 1'b0, 1'b0);
        tick();
        s_reset = 1'b0;
        s_expect("mid_rst", 1'b0, NOP, 1'b1, 2'd0);
        check("mid_rst_stall", s_o_stall, 0);

        run_random(1'b1, 3000);

        fork
            begin
                // Stall counter saturation on the skid instance.
                s_reset = 1'b1;
                s_set(1'b0, '0, 1'b0, 1'b0);
                tick();
                s_reset = 1'b0;
                s_set(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0);
                tick();
                s_set(1'b0, '0, 1'b0, 1'b0);
                for (int n = 1; n <= 70000; n++) begin
                    tick();
                    if (n == 65534) check("sat_fffe", s_o_stall, 16'hFFFE);
                    if (n == 65535) check("sat_ffff", s_o_stall, 16'hFFFF);
                    if (n == 65536) check("sat_hold", s_o_stall, 16'hFFFF);
                end
                check("sat_end", s_o_stall, 16'hFFFF);
                check("sat_data", s_o_data, 32'h5A5A_5A5A);
                s_set(1'b0, '0, 1'b0, 1'b1);
                tick();
                check("sat_flush_stall", s_o_stall, 16'hFFFF);
                check("sat_flush_valid", s_o_valid, 1'b0);
                s_set(1'b0, '0, 1'b0, 1'b0);
            end
            begin
                run_random(1'b0, 10000);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
